// File: rtl/mem_stage_pipe_pkg.sv
// Shared definitions for the MEM pipeline stage: memory-op encodings, op
// decode helpers and the request FSM state type.
package mem_stage_pkg;

  localparam int unsigned MEMOP_W = 4;

  typedef enum logic [MEMOP_W-1:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LBU  = 4'd2,
    OP_LH   = 4'd3,
    OP_LHU  = 4'd4,
    OP_LW   = 4'd5,
    OP_LWU  = 4'd6,
    OP_LD   = 4'd7,
    OP_SB   = 4'd8,
    OP_SH   = 4'd9,
    OP_SW   = 4'd10,
    OP_SD   = 4'd11
  } mem_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Unknown encodings and 64-bit-only ops on a 32-bit datapath decode as NONE.
  function automatic mem_op_e op_effective(input logic [MEMOP_W-1:0] raw,
                                           input int unsigned xlen);
    mem_op_e op;
    if (raw > OP_SD) op = OP_NONE;
    else             op = mem_op_e'(raw);
    if (xlen < 64 && (op == OP_LWU || op == OP_LD || op == OP_SD)) op = OP_NONE;
    return op;
  endfunction

  // log2 of the access size in bytes
  function automatic logic [1:0] op_size(input mem_op_e op);
    case (op)
      OP_LH, OP_LHU, OP_SH: return 2'd1;
      OP_LW, OP_LWU, OP_SW: return 2'd2;
      OP_LD, OP_SD:         return 2'd3;
      default:              return 2'd0;
    endcase
  endfunction

  function automatic logic op_signed(input mem_op_e op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW);
  endfunction

  function automatic logic op_is_store(input mem_op_e op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW) || (op == OP_SD);
  endfunction

  function automatic logic op_is_load(input mem_op_e op);
    return (op >= OP_LB) && (op <= OP_LD);
  endfunction

endpackage

// File: rtl/mem_stage_pipe_lane_align.sv
// Combinational lane logic: store byte enables / replicated write data,
// load extraction with sign/zero extension, and misalignment detection.
module mem_lane_align
  import mem_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NB   = XLEN / 8,
  parameter int unsigned OB   = $clog2(XLEN / 8)
) (
  input  logic [MEMOP_W-1:0] i_op,
  input  logic [OB-1:0]      i_lane,
  input  logic [XLEN-1:0]    i_sdata,
  input  logic [XLEN-1:0]    i_rdata,
  output logic               o_is_mem,
  output logic               o_is_store,
  output logic               o_misalign,
  output logic [NB-1:0]      o_be,
  output logic [XLEN-1:0]    o_wdata,
  output logic [XLEN-1:0]    o_ldata
);

  mem_op_e           w_op;
  logic [3:0]        w_bytes;
  logic [3:0]        w_lane4;
  logic [XLEN-1:0]   w_mask;
  logic [XLEN-1:0]   w_src;
  logic [XLEN-1:0]   w_shift;
  logic [XLEN-1:0]   w_top;

  always_comb begin
    w_op       = op_effective(i_op, XLEN);
    w_bytes    = 4'd1 << op_size(w_op);
    w_lane4    = 4'(i_lane);
    o_is_store = op_is_store(w_op);
    o_is_mem   = o_is_store || op_is_load(w_op);
    o_misalign = o_is_mem && ((w_lane4 & (w_bytes - 4'd1)) != 4'd0);

    w_mask  = '0;
    w_src   = '0;
    o_be    = '0;
    o_wdata = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      w_mask[i*8 +: 8]  = (i < 32'(w_bytes)) ? 8'hFF : 8'h00;
      o_be[i]           = (i >= 32'(i_lane)) && (i < 32'(i_lane) + 32'(w_bytes));
      // Datum repeats every access-size bytes across the bus.
      w_src             = i_sdata >> ((i & (32'(w_bytes) - 1)) * 8);
      o_wdata[i*8 +: 8] = w_src[7:0];
    end

    w_shift = i_rdata >> (32'(i_lane) * 8);
    w_top   = w_shift >> (32'(w_bytes) * 8 - 1);
    o_ldata = w_shift & w_mask;
    if (op_signed(w_op) && w_top[0]) o_ldata = o_ldata | ~w_mask;
  end

endmodule

// File: rtl/mem_stage_pipe.sv
// MEM pipeline stage: issues loads/stores on a req/ack data-memory port,
// aligns data, flags misaligned accesses and forwards EX fields to WB.
module mem_stage_pipe
  import mem_stage_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned AW    = 32,
  parameter int unsigned SIG_W = 16,
  parameter int unsigned DST_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_pc,
  input  logic [31:0]        in_ir,
  input  logic [SIG_W-1:0]   in_signal,
  input  logic [DST_W-1:0]   in_dst,
  input  logic [XLEN-1:0]    in_r2,
  input  logic [XLEN-1:0]    in_r,
  input  logic [XLEN-1:0]    in_v0,
  input  logic [XLEN-1:0]    in_a0,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_pc,
  output logic [31:0]        out_ir,
  output logic [SIG_W-1:0]   out_signal,
  output logic [DST_W-1:0]   out_dst,
  output logic [XLEN-1:0]    out_v0,
  output logic [XLEN-1:0]    out_a0,
  output logic [XLEN-1:0]    out_r,
  output logic               out_misalign,
  output logic               mem_req,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [XLEN/8-1:0]  mem_be,
  output logic [XLEN-1:0]    mem_wdata,
  input  logic               mem_ack,
  input  logic [XLEN-1:0]    mem_rdata
);

  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned OB = $clog2(NB);

  state_e              r_state, w_state_nxt;
  logic                r_out_valid;
  logic [31:0]         r_out_pc, r_out_ir;
  logic [SIG_W-1:0]    r_out_signal;
  logic [DST_W-1:0]    r_out_dst;
  logic [XLEN-1:0]     r_out_v0, r_out_a0, r_out_r;
  logic                r_out_misalign;
  logic                r_mem_req, r_mem_we;
  logic [AW-1:0]       r_mem_addr;
  logic [NB-1:0]       r_mem_be;
  logic [XLEN-1:0]     r_mem_wdata;
  logic [MEMOP_W-1:0]  r_op;
  logic [OB-1:0]       r_lane;

  logic                w_accept, w_issue, w_done;
  logic [MEMOP_W-1:0]  w_al_op;
  logic [OB-1:0]       w_al_lane;
  logic                w_is_mem, w_is_store, w_misalign;
  logic [NB-1:0]       w_be;
  logic [XLEN-1:0]     w_wdata, w_ldata;

  assign in_ready = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_issue  = w_accept && w_is_mem && !w_misalign;
  assign w_done   = (r_state == ST_WAIT) && mem_ack;

  // One aligner serves both phases: the incoming op while idle, the held op while waiting.
  assign w_al_op   = (r_state == ST_WAIT) ? r_op   : in_signal[MEMOP_W-1:0];
  assign w_al_lane = (r_state == ST_WAIT) ? r_lane : in_r[OB-1:0];

  mem_lane_align #(.XLEN(XLEN)) u_align (
    .i_op       (w_al_op),
    .i_lane     (w_al_lane),
    .i_sdata    (in_r2),
    .i_rdata    (mem_rdata),
    .o_is_mem   (w_is_mem),
    .o_is_store (w_is_store),
    .o_misalign (w_misalign),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_ldata    (w_ldata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_issue) w_state_nxt = ST_WAIT;
      ST_WAIT: if (mem_ack) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid    <= 1'b0;
      r_out_pc       <= '0;
      r_out_ir       <= '0;
      r_out_signal   <= '0;
      r_out_dst      <= '0;
      r_out_v0       <= '0;
      r_out_a0       <= '0;
      r_out_r        <= '0;
      r_out_misalign <= 1'b0;
      r_mem_req      <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_be       <= '0;
      r_mem_wdata    <= '0;
      r_op           <= '0;
      r_lane         <= '0;
    end else begin
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;

      // Pass-through fields are captured at accept; WAIT only ever runs with the out slot empty.
      if (w_accept) begin
        r_out_pc       <= in_pc;
        r_out_ir       <= in_ir;
        r_out_signal   <= in_signal;
        r_out_dst      <= in_dst;
        r_out_v0       <= in_v0;
        r_out_a0       <= in_a0;
        r_out_r        <= in_r;
        r_out_misalign <= w_misalign;
        if (w_issue) begin
          r_mem_req   <= 1'b1;
          r_mem_we    <= w_is_store;
          r_mem_addr  <= {in_r[AW-1:OB], {OB{1'b0}}};
          r_mem_be    <= w_be;
          r_mem_wdata <= w_wdata;
          r_op        <= in_signal[MEMOP_W-1:0];
          r_lane      <= in_r[OB-1:0];
        end else begin
          r_out_valid <= 1'b1;
        end
      end

      if (w_done) begin
        r_mem_req   <= 1'b0;
        r_out_valid <= 1'b1;
        if (!r_mem_we) r_out_r <= w_ldata;
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign out_pc       = r_out_pc;
  assign out_ir       = r_out_ir;
  assign out_signal   = r_out_signal;
  assign out_dst      = r_out_dst;
  assign out_v0       = r_out_v0;
  assign out_a0       = r_out_a0;
  assign out_r        = r_out_r;
  assign out_misalign = r_out_misalign;
  assign mem_req      = r_mem_req;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_be       = r_mem_be;
  assign mem_wdata    = r_mem_wdata;

endmodule
